// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and default parameter values for the register
// file bank. Holds the bulk-clear state encoding and default sizing.
package regfile_pkg;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_NUM_REGS  = 32;
  localparam int DEF_NUM_RD    = 2;
  localparam int DEF_BYPASS    = 1;
  localparam int DEF_ZERO_REG0 = 1;

  // Bulk-clear sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_t;

endpackage

// File: rtl/regfile_rd_mux.sv
// regfile_rd_mux: NUM_REGS-to-1 selector of DATA_W-bit words.
// Ports:
//   regs_i  - all registers, packed; register i at [i*DATA_W +: DATA_W]
//   sel_i   - register index
//   data_o  - selected register, zero when sel_i >= NUM_REGS
module regfile_rd_mux #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic [NUM_REGS*DATA_W-1:0] regs_i,
  input  logic [AW-1:0]              sel_i,
  output logic [DATA_W-1:0]          data_o
);

  // Indices with no matching register leave the zero default in place.
  always_comb begin
    data_o = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (sel_i == AW'(i)) begin
        data_o = regs_i[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/regfile_bank.sv
// regfile_bank: multi-port register file with combinational reads, one
// write port with optional write-to-read forwarding, optional hardwired
// zero register 0, and a sequential bulk-clear engine.
// Ports:
//   i_clk       - clock, rising edge
//   i_rst_n     - asynchronous active-low reset (zeroes all state)
//   i_rd_addr   - packed read addresses, port k at [k*AW +: AW]
//   o_rd_data   - packed read data, port k at [k*DATA_W +: DATA_W]
//   i_wr_en     - write enable (honoured only while the clear engine is idle)
//   i_wr_addr   - write address
//   i_wr_data   - write data
//   i_clr_req   - pulse to start a bulk clear (ignored while one is running)
//   o_clr_busy  - high while clearing and in the completion cycle
//   o_clr_done  - one-cycle pulse in the completion cycle
module regfile_bank
  import regfile_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_REGS  = DEF_NUM_REGS,
  parameter int NUM_RD    = DEF_NUM_RD,
  parameter int BYPASS    = DEF_BYPASS,
  parameter int ZERO_REG0 = DEF_ZERO_REG0,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_RD*AW-1:0]     i_rd_addr,
  output logic [NUM_RD*DATA_W-1:0] o_rd_data,
  input  logic                     i_wr_en,
  input  logic [AW-1:0]            i_wr_addr,
  input  logic [DATA_W-1:0]        i_wr_data,
  input  logic                     i_clr_req,
  output logic                     o_clr_busy,
  output logic                     o_clr_done
);

  clr_state_t                 state_q, state_d;
  logic [AW-1:0]              cnt_q, cnt_d;
  logic [DATA_W-1:0]          regs_q [NUM_REGS];
  logic [NUM_REGS*DATA_W-1:0] regs_flat;

  logic idle;
  logic wr_in_range;
  logic wr_zero_blk;
  logic wr_commit;
  logic clr_we;

  assign idle        = (state_q == IDLE);
  assign wr_in_range = (int'(i_wr_addr) < NUM_REGS);
  assign wr_zero_blk = (ZERO_REG0 != 0) && (i_wr_addr == '0);
  // A write that will really land in the array; forwarding keys off the
  // same condition so a read never sees data that will not be stored.
  assign wr_commit   = i_wr_en && idle && wr_in_range && !wr_zero_blk;
  assign clr_we      = (state_q == CLEAR);

  // Clear sequencer: next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (i_clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (cnt_q == AW'(NUM_REGS - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_clr_busy = (state_q != IDLE);
  assign o_clr_done = (state_q == DONE);

  // Register array: clear and write are mutually exclusive by state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (clr_we && (cnt_q == AW'(i))) begin
          regs_q[i] <= '0;
        end else if (wr_commit && (i_wr_addr == AW'(i))) begin
          regs_q[i] <= i_wr_data;
        end
      end
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_flat[i*DATA_W +: DATA_W] = regs_q[i];
    end
  end

  // Read ports
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] stored;
    logic              fwd;

    assign addr = i_rd_addr[k*AW +: AW];

    regfile_rd_mux #(
      .DATA_W  (DATA_W),
      .NUM_REGS(NUM_REGS),
      .AW      (AW)
    ) u_mux (
      .regs_i(regs_flat),
      .sel_i (addr),
      .data_o(stored)
    );

    assign fwd = (BYPASS != 0) && wr_commit && (addr == i_wr_addr);
    assign o_rd_data[k*DATA_W +: DATA_W] = fwd ? i_wr_data : stored;
  end

endmodule

// File: tb/tb_regfile_bank.sv
module tb_regfile_bank;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [9:0]  rd_addr;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        clr_req;

  logic [63:0] rd_b, rd_n, rd_s;
  logic        busy_b, done_b, busy_n, done_n, busy_s, done_s;

  // Main instance: 32 regs, forwarding, zero reg 0.
  regfile_bank #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .BYPASS(1), .ZERO_REG0(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rd_addr(rd_addr), .o_rd_data(rd_b),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_clr_req(clr_req), .o_clr_busy(busy_b), .o_clr_done(done_b));

  // Same, without forwarding.
  regfile_bank #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .BYPASS(0), .ZERO_REG0(1)) dut_nb (
    .i_clk(clk), .i_rst_n(rst_n), .i_rd_addr(rd_addr), .o_rd_data(rd_n),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_clr_req(clr_req), .o_clr_busy(busy_n), .o_clr_done(done_n));

  // 24 regs: addresses 24..31 are out of range; reg 0 is an ordinary register.
  regfile_bank #(.DATA_W(32), .NUM_REGS(24), .NUM_RD(2), .BYPASS(1), .ZERO_REG0(0)) dut_s (
    .i_clk(clk), .i_rst_n(rst_n), .i_rd_addr(rd_addr), .o_rd_data(rd_s),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_clr_req(1'b0), .o_clr_busy(busy_s), .o_clr_done(done_s));

  // Reference model
  logic [31:0] mem_b [32];
  logic [31:0] mem_s [24];
  int          clr_idx;   // -1: idle, 0..31: next reg to clear, 32: completion cycle
  int          nerrs  = 0;
  int          nchecks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    if (obs !== exp) begin
      nerrs++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_big(input int a, input bit byp);
    if (a == 0) return 32'h0;
    if (byp && clr_idx < 0 && wr_en && a == int'(wr_addr)) return wr_data;
    return mem_b[a];
  endfunction

  function automatic logic [31:0] exp_small(input int a);
    if (a >= 24) return 32'h0;
    if (wr_en && a == int'(wr_addr)) return wr_data;
    return mem_s[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mem_b[i] = '0;
    for (int i = 0; i < 24; i++) mem_s[i] = '0;
    clr_idx = -1;
  endtask

  // Applies the effect of one rising edge with the inputs currently driven.
  task automatic model_update();
    if (clr_idx < 0) begin
      if (wr_en && wr_addr != 5'd0) mem_b[wr_addr] = wr_data;
      if (clr_req) clr_idx = 0;
    end else if (clr_idx < 32) begin
      mem_b[clr_idx] = '0;
      clr_idx++;
    end else begin
      clr_idx = -1;
    end
    if (wr_en && int'(wr_addr) < 24) mem_s[wr_addr] = wr_data;
  endtask

  task automatic check_all();
    for (int p = 0; p < 2; p++) begin
      int a;
      a = int'(rd_addr[p*5 +: 5]);
      chk("rd_byp",   rd_b[p*32 +: 32], exp_big(a, 1'b1));
      chk("rd_nobyp", rd_n[p*32 +: 32], exp_big(a, 1'b0));
      chk("rd_small", rd_s[p*32 +: 32], exp_small(a));
    end
    chk("busy",      {31'd0, busy_b}, {31'd0, clr_idx >= 0});
    chk("done",      {31'd0, done_b}, {31'd0, clr_idx == 32});
    chk("busy_nb",   {31'd0, busy_n}, {31'd0, clr_idx >= 0});
    chk("done_nb",   {31'd0, done_n}, {31'd0, clr_idx == 32});
    chk("busy_s",    {31'd0, busy_s | done_s}, 32'd0);
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic cyc();
    #1;
    check_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; clr_req = 1'b0; wr_addr = '0; wr_data = '0;
  endtask

  task automatic apply_reset(input int cycles);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_busy", {31'd0, busy_b}, 32'd0);
    chk("rst_done", {31'd0, done_b}, 32'd0);
    check_all();
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain_clear(input int budget);
    int n;
    n = 0;
    while ((busy_b || clr_idx >= 0) && n < budget) begin
      cyc();
      n++;
    end
    if (n >= budget) chk("clear_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    rst_n = 1'b1; rd_addr = '0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    apply_reset(2);

    // After release every port reads zero.
    for (int a = 0; a < 32; a += 2) begin
      rd_addr = {5'(a + 1), 5'(a)};
      #1;
      chk("post_rst_p0", rd_b[31:0], 32'h0);
      chk("post_rst_p1", rd_b[63:32], 32'h0);
      cyc();
    end

    // Write then read back; neighbour stays zero.
    wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF;
    cyc();
    idle_inputs();
    rd_addr = {5'd6, 5'd5};
    #1;
    chk("wr_rd_p0", rd_b[31:0], 32'hDEADBEEF);
    chk("wr_rd_p1", rd_b[63:32], 32'h0);
    cyc();

    // Same-cycle forwarding vs stored value.
    wr_en = 1; wr_addr = 7; wr_data = 32'h12345678; rd_addr = {5'd7, 5'd7};
    #1;
    chk("bypass_on",  rd_b[63:32], 32'h12345678);
    chk("bypass_off", rd_n[63:32], 32'h0);
    chk("ports_eq",   rd_b[31:0], rd_b[63:32]);
    cyc();
    idle_inputs();
    #1;
    chk("nobyp_next", rd_n[63:32], 32'h12345678);
    cyc();

    // Writes to reg 0 are dropped; reg 0 in the small instance is normal.
    wr_en = 1; wr_addr = 0; wr_data = 32'hFFFFFFFF; rd_addr = {5'd0, 5'd0};
    #1;
    chk("zero_same_p0", rd_b[31:0], 32'h0);
    chk("zero_same_p1", rd_b[63:32], 32'h0);
    cyc();
    idle_inputs();
    #1;
    chk("zero_later", rd_b[31:0] | rd_b[63:32] | rd_n[31:0], 32'h0);
    chk("small_reg0", rd_s[31:0], 32'hFFFFFFFF);
    cyc();

    // Out-of-range write and read on the small instance.
    wr_en = 1; wr_addr = 26; wr_data = 32'hCAFEF00D; rd_addr = {5'd26, 5'd31};
    #1;
    chk("oor_nobyp", rd_s[63:32], 32'h0);
    cyc();
    idle_inputs();
    cyc();

    // Full clear with a write attempted on the second busy cycle.
    for (int i = 1; i < 32; i++) begin
      wr_en = 1; wr_addr = 5'(i); wr_data = 32'(i);
      cyc();
    end
    idle_inputs();
    clr_req = 1;
    cyc();
    clr_req = 0;
    begin
      int nbusy, ndone, done_pos;
      nbusy = 0; ndone = 0; done_pos = 0;
      rd_addr = {5'd3, 5'd31};
      for (int i = 0; i < 100 && (i == 0 || busy_b); i++) begin
        if (nbusy == 1) begin
          wr_en = 1; wr_addr = 3; wr_data = 32'h77;
        end else begin
          wr_en = 0;
        end
        #1;
        if (busy_b) nbusy++;
        if (done_b) begin ndone++; done_pos = nbusy; end
        cyc();
      end
      idle_inputs();
      chk("busy_len",  32'(nbusy), 32'd33);
      chk("done_cnt",  32'(ndone), 32'd1);
      chk("done_pos",  32'(done_pos), 32'd33);
    end
    for (int a = 0; a < 32; a += 2) begin
      rd_addr = {5'(a + 1), 5'(a)};
      #1;
      chk("cleared_p0", rd_b[31:0], 32'h0);
      chk("cleared_p1", rd_b[63:32], 32'h0);
      cyc();
    end

    // Reset in the middle of a clear.
    for (int i = 1; i < 32; i++) begin
      wr_en = 1; wr_addr = 5'(i); wr_data = 32'hA000_0000 | 32'(i);
      cyc();
    end
    idle_inputs();
    clr_req = 1;
    cyc();
    clr_req = 0;
    repeat (10) cyc();
    chk("mid_busy", {31'd0, busy_b}, 32'd1);
    apply_reset(2);
    for (int a = 0; a < 32; a += 2) begin
      rd_addr = {5'(a + 1), 5'(a)};
      #1;
      chk("abort_done", {31'd0, done_b}, 32'd0);
      chk("abort_rd",   rd_b[31:0] | rd_b[63:32], 32'h0);
      cyc();
    end

    // Simultaneous write and clear request.
    clr_req = 1; wr_en = 1; wr_addr = 9; wr_data = 32'hA5; rd_addr = {5'd9, 5'd9};
    cyc();
    idle_inputs();
    cyc();
    cyc();
    #1;
    chk("wc_early", rd_b[31:0], 32'hA5);
    cyc();
    drain_clear(100);
    #1;
    chk("wc_after", rd_b[31:0], 32'h0);
    cyc();

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      wr_en   = ($urandom_range(0, 9) < 6);
      wr_addr = 5'($urandom_range(0, 31));
      wr_data = $urandom;
      clr_req = ($urandom_range(0, 59) == 0);
      rd_addr[4:0] = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      rd_addr[9:5] = ($urandom_range(0, 3) == 0) ? rd_addr[4:0] : 5'($urandom_range(0, 31));
      cyc();
    end
    idle_inputs();
    drain_clear(100);

    $display("Result: errors=%0d of %0d checks", nerrs, nchecks);
    $finish;
  end

endmodule

// File: doc/regfile_bank.md
REGFILE_BANK -- requirements
Module: regfile_bank

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the register and data width in bits.
REQ-002 Parameter NUM_REGS, default 32, SHALL set the register count; the legal range is 2..64.
REQ-003 Parameter NUM_RD, default 2, SHALL set the number of independent read ports; the legal range is 1..4.
REQ-004 Parameter BYPASS, default 1, SHALL enable write-to-read forwarding when set to 1.
REQ-005 Parameter ZERO_REG0, default 1, SHALL hardwire register 0 to zero when set to 1.
REQ-006 Localparam AW SHALL equal $clog2(NUM_REGS).
REQ-007 i_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-008 i_rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-009 i_rd_addr  input  NUM_RD*AW  SHALL carry the packed read addresses; port k uses bits [k*AW +: AW].
REQ-010 o_rd_data  output  NUM_RD*DATA_W  SHALL carry the packed read data; port k uses bits [k*DATA_W +: DATA_W].
REQ-011 i_wr_en  input  1  SHALL be the write enable.
REQ-012 i_wr_addr  input  AW  SHALL be the write address.
REQ-013 i_wr_data  input  DATA_W  SHALL be the write data.
REQ-014 i_clr_req  input  1  SHALL be a single-cycle request to start a bulk clear.
REQ-015 o_clr_busy  output  1  SHALL be high while a clear sequence is in progress.
REQ-016 o_clr_done  output  1  SHALL be a one-cycle pulse when a clear sequence completes.

Function
REQ-017 Each read port SHALL be combinational, with zero latency, and SHALL return the register at its address.
REQ-018 A read address >= NUM_REGS SHALL return all zeros.
REQ-019 With ZERO_REG0=1, address 0 SHALL always read 0, and writes to address 0 SHALL be discarded.
REQ-020 When i_wr_en=1 and the FSM is in IDLE, the register at i_wr_addr SHALL take i_wr_data on the next rising edge.
REQ-021 A write to an address >= NUM_REGS SHALL be discarded.
REQ-022 With BYPASS=1 and the FSM in IDLE, a read port whose address equals i_wr_addr while i_wr_en=1 SHALL return i_wr_data in the same cycle.
REQ-023 REQ-022 SHALL NOT apply to address 0 when ZERO_REG0=1, nor to out-of-range addresses.
REQ-024 With BYPASS=0, a read SHALL always return the stored value; the new data appears the cycle after the write.
REQ-025 All read ports SHALL operate independently; identical addresses on several ports SHALL return identical data.
REQ-026 The clear FSM SHALL have three states: IDLE, CLEAR and DONE.
REQ-027 In IDLE, i_clr_req=1 SHALL cause a transition to CLEAR with the clear counter set to 0.
REQ-028 In CLEAR, each cycle SHALL zero register[counter] and increment the counter.
REQ-029 When counter = NUM_REGS-1 in CLEAR, that last register SHALL be zeroed and the FSM SHALL go to DONE.
REQ-030 DONE SHALL last exactly one cycle, SHALL assert o_clr_done=1, and SHALL then return to IDLE.
REQ-031 o_clr_busy SHALL be high in CLEAR and DONE, giving a total busy time of NUM_REGS+1 cycles.
REQ-032 In CLEAR and DONE, i_wr_en SHALL be ignored (the clear has priority), the write is lost, and bypass SHALL be disabled.
REQ-033 i_clr_req in CLEAR or DONE SHALL be ignored; it is not queued.
REQ-034 If i_clr_req and i_wr_en are both high in IDLE in the same cycle, the write SHALL commit and the clear SHALL start; the clear later zeroes that register.
REQ-035 Reads during CLEAR SHALL return the current stored values, i.e. partially cleared contents.

Reset
REQ-036 i_rst_n=0 SHALL, asynchronously, zero every register, set the FSM to IDLE, set the counter to 0, and drive o_clr_busy=0 and o_clr_done=0.
REQ-037 A reset asserted mid-clear SHALL abort the sequence; after release the FSM SHALL be in IDLE with no o_clr_done pulse.
REQ-038 After reset release, every o_rd_data port SHALL read 0.

Structure
REQ-039 Package regfile_pkg SHALL hold the clr_state_t enum (IDLE, CLEAR, DONE) and the default parameter constants.
REQ-040 One sub-module, regfile_rd_mux, SHALL provide a parametrised NUM_REGS-to-1 DATA_W-bit selector with zero for out-of-range selects.
REQ-041 regfile_bank SHALL instantiate regfile_rd_mux once per read port through a generate loop.

Verification
REQ-042 Reset, then write 0xDEADBEEF to reg 5, then read port 0 at addr 5 the next cycle -> 0xDEADBEEF; port 1 at addr 6 -> 0.
REQ-043 With BYPASS=1, write 0x12345678 to reg 7 while port 1 reads addr 7 -> 0x12345678 in the same cycle; with BYPASS=0 -> the old value 0.
REQ-044 Write 0xFFFFFFFF to reg 0 with ZERO_REG0=1, then read addr 0 on all ports -> 0 in the same cycle and every later cycle.
REQ-045 Fill regs 1..31 with their own index, pulse i_clr_req, and issue a write to reg 3 on the 2nd busy cycle -> busy for 33 cycles, a done pulse in the last busy cycle, all regs then read 0, and reg 3 is not rewritten.
REQ-046 Assert i_rst_n=0 at clear cycle 10 -> busy drops immediately, no done pulse, and all regs read 0 after release.
REQ-047 Assert i_clr_req and a write of 0xA5 to reg 9 in the same IDLE cycle -> reg 9 reads 0xA5 during the first cycles of the clear, then 0 after done.
